// File: rtl/accum_8_bits.sv
// Frame accumulator: sums COUNT_N two's-complement operands per frame and
// presents the wrapped sum plus a sticky signed-overflow flag, held until the
// downstream handshake. All outputs are registered.
module accum_8_bits #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:WIDTH]   in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(COUNT_N);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sum;
  logic [7:0]       cnt_inc;
  logic             v;
  logic             accept;
  logic             handshake;

  // in_data is declared MSB-first at index 1; positional copy keeps MSB on top
  assign din       = in_data;
  assign sum       = acc_q + din;
  assign cnt_inc   = cnt_q + 8'd1;
  // Signed overflow: same-sign operands producing a result of the other sign
  assign v         = (acc_q[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
  assign accept    = in_valid && in_ready_q;
  assign handshake = out_valid_q && out_ready;

  // Next-state and registered-output logic for the IDLE/ACCUM/HOLD frame FSM
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE: begin
        // in_ready rises here on the first edge after reset release
        in_ready_d = 1'b1;
        if (accept) begin
          acc_d = din;
          ovf_d = 1'b0;
          cnt_d = 8'd1;
          if (CNT_LAST == 8'd1) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = din;
            out_ovf_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | v;
          if (cnt_inc == CNT_LAST) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_ovf_d   = ovf_q | v;
          end
        end
      end
      HOLD: begin
        in_ready_d = 1'b0;
        if (handshake) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial frame or pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_accum_8_bits.sv
// Directed bench for accum_8_bits: table of 4-operand frames with expected
// sum/overflow, plus hand-written reset and backpressure sequences.
module tb_accum_8_bits;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:8] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0][7:0] ops;   // ops[3] is sent first
    logic [7:0]      exp_sum;
    logic            exp_ovf;
    int              stall;
  } frame_t;

  frame_t vec [6];

  accum_8_bits #(
    .WIDTH   (8),
    .COUNT_N (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle and ready; returns at a negedge, idle again
  task automatic run_frame(input string tag, input logic [3:0][7:0] ops,
                           input logic [7:0] exp_sum, input logic exp_ovf, input int stall);
    out_ready = (stall == 0);
    for (int i = 3; i >= 0; i--) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, " busy"}, 32'(busy), (i != 0) ? 32'd1 : 32'd0);
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    check({tag, " in_ready in hold"}, 32'(in_ready), 32'd0);
    if (stall > 0) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " stall out_sum"}, 32'(out_sum), 32'(exp_sum));
        check({tag, " stall out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    check({tag, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec[0] = '{ops: {8'h01, 8'h01, 8'h01, 8'h01}, exp_sum: 8'h04, exp_ovf: 1'b0, stall: 0};
    vec[1] = '{ops: {8'h7F, 8'h01, 8'h00, 8'h00}, exp_sum: 8'h80, exp_ovf: 1'b1, stall: 0};
    vec[2] = '{ops: {8'h02, 8'h03, 8'h00, 8'h00}, exp_sum: 8'h05, exp_ovf: 1'b0, stall: 0};
    vec[3] = '{ops: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp_sum: 8'hFC, exp_ovf: 1'b0, stall: 0};
    vec[4] = '{ops: {8'h40, 8'h40, 8'hC0, 8'hC0}, exp_sum: 8'h00, exp_ovf: 1'b1, stall: 0};
    vec[5] = '{ops: {8'h80, 8'hFF, 8'h01, 8'h00}, exp_sum: 8'h80, exp_ovf: 1'b1, stall: 5};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset held across an edge: everything quiet
    #7;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_ovf", 32'(out_ovf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release in_ready before edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release in_ready after edge", 32'(in_ready), 32'd1);

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("vec%0d", k), vec[k].ops, vec[k].exp_sum, vec[k].exp_ovf, vec[k].stall);
    end

    // Backpressure must not have consumed any of the 0x55 operands
    run_frame("post-stall", {8'h01, 8'h01, 8'h01, 8'h01}, 8'h04, 1'b0, 0);

    // Asynchronous reset mid-cycle while holding a result with ovf set
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h7F;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold before async reset out_ovf", 32'(out_ovf), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_sum", 32'(out_sum), 32'd0);
    check("async reset out_ovf", 32'(out_ovf), 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("after async reset in_ready", 32'(in_ready), 32'd1);
    check("after async reset out_valid", 32'(out_valid), 32'd0);

    // Reset mid-frame: partial sum must be discarded
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid-frame busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-frame reset busy", 32'(busy), 32'd0);
    check("mid-frame reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-frame reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    run_frame("after mid-frame reset", {8'h01, 8'h01, 8'h01, 8'h01}, 8'h04, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
